// File: rtl/helen_pio_pkg.sv
// Shared defaults, status field positions and fill-side state encoding for the PIO readout loader.
package helen_pio_pkg;

    localparam int DEF_N_WORDS = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIME_W  = 26;
    localparam int DEF_SEQ_W   = 16;

    localparam int STATUS_VALID_BIT = 0;
    localparam int STATUS_SEQ_LSB   = 16;

    typedef logic [DEF_N_WORDS-1:0][DEF_DATA_W-1:0] word_bank_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/pio_pkt_shadow.sv
// Shadow buffer: gathers N_WORDS stream words plus the first-word timestamp.
// Latency: word stored on its accept edge; full flag set on the last accept edge.
// Backpressure: in_ready low from the last accept until the top swaps the packet out.
module pio_pkt_shadow
    import helen_pio_pkg::*;
#(
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIME_W  = DEF_TIME_W
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset_n,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic [TIME_W-1:0]                time_in,
    input  logic                             swap,
    output logic [N_WORDS-1:0][DATA_W-1:0]   shadow,
    output logic [TIME_W-1:0]                shadow_time,
    output logic                             fill_full
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    fill_state_t      state;
    fill_state_t      state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && (idx == LAST_IDX)) state_nxt = FULL;
            FULL:    if (swap) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        fill_full = (state == FULL);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            idx <= '0;
        end else if (swap) begin
            idx <= '0;
        end else if (accept) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Payload storage is not reset: a discarded partial packet is simply overwritten.
    always_ff @(posedge clk_clk) begin
        if (accept) begin
            shadow[idx] <= in_data;
            if (idx == '0) begin
                shadow_time <= time_in;
            end
        end
    end

endmodule

// File: rtl/ddc_pio_loader.sv
// Publishes shadow packets onto the flat PIO bank with a sequence/status word, swapping on HPS ack toggles.
// Latency: swap one edge after the shadow fills (bank empty) or on the ack edge (bank occupied).
// Backpressure: upstream stalls while a full shadow waits for the bank to free; nothing is dropped.
module ddc_pio_loader
    import helen_pio_pkg::*;
#(
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIME_W  = DEF_TIME_W,
    parameter int SEQ_W   = DEF_SEQ_W
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic [TIME_W-1:0]           time_in,
    input  logic                        hps_read_bit,
    output logic [N_WORDS*DATA_W-1:0]   pio_data,
    output logic [TIME_W-1:0]           pio_time,
    output logic [31:0]                 pio_status
);

    logic [N_WORDS-1:0][DATA_W-1:0] shadow;
    logic [TIME_W-1:0]              shadow_time;
    logic                           fill_full;
    logic                           swap;
    logic                           ack;
    logic                           hps_read_bit_q;
    logic                           armed;
    logic                           bank_valid;
    logic [SEQ_W-1:0]               seq;

    pio_pkt_shadow #(
        .N_WORDS (N_WORDS),
        .DATA_W  (DATA_W),
        .TIME_W  (TIME_W)
    ) u_shadow (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .time_in       (time_in),
        .swap          (swap),
        .shadow        (shadow),
        .shadow_time   (shadow_time),
        .fill_full     (fill_full)
    );

    // hps_read_bit may already differ from its reset-time copy on release; armed hides that.
    assign ack  = armed && (hps_read_bit != hps_read_bit_q);
    assign swap = fill_full && (!bank_valid || ack);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hps_read_bit_q <= 1'b0;
            armed          <= 1'b0;
            bank_valid     <= 1'b0;
            seq            <= '0;
            pio_data       <= '0;
            pio_time       <= '0;
        end else begin
            hps_read_bit_q <= hps_read_bit;
            armed          <= 1'b1;
            if (swap) begin
                pio_data   <= shadow;
                pio_time   <= shadow_time;
                bank_valid <= 1'b1;
                seq        <= seq + 1'b1;
            end else if (ack) begin
                bank_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        pio_status                               = '0;
        pio_status[STATUS_SEQ_LSB +: SEQ_W]      = seq;
        pio_status[STATUS_VALID_BIT]             = bank_valid;
    end

endmodule
